// File: rtl/led_code_sequencer.sv
// Running-light code generator for a 3-to-8 LED decoder: a prescaled up/down
// 3-bit counter with debounced pause/resume and direction push-buttons.
module led_code_sequencer #(
  parameter int CNT_MAX      = 24_999_999,
  parameter int DEBOUNCE_MAX = 999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_pause,
  input  logic       key_dir,
  output logic [2:0] code_out,
  output logic       step,
  output logic       running
);

  localparam int PW = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int KW = $clog2(DEBOUNCE_MAX + 1);
  localparam logic [PW-1:0] PCNT_MAX = PW'(CNT_MAX);
  localparam logic [KW-1:0] KCNT_MAX = KW'(DEBOUNCE_MAX);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_PAUSE = 1'b1
  } state_t;

  // Key index 0 is pause, index 1 is direction.
  logic [1:0]    key_raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    press;
  logic [KW-1:0] kcnt [2];

  state_t        state;
  state_t        state_nx;
  logic          tick;
  logic [PW-1:0] pcnt;
  logic          dir;

  assign key_raw = {key_dir, key_pause};

  // Press fires on the cycle kcnt reaches DEBOUNCE_MAX; saturation keeps a held key to one pulse.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      press   <= 2'b00;
      kcnt[0] <= '0;
      kcnt[1] <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i]) begin
          kcnt[i]  <= '0;
          press[i] <= 1'b0;
        end else if (kcnt[i] < KCNT_MAX) begin
          kcnt[i]  <= kcnt[i] + 1'b1;
          press[i] <= (kcnt[i] == KCNT_MAX - 1'b1);
        end else begin
          press[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_RUN;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tick     = 1'b0;
    if (press[0]) state_nx = (state == S_RUN) ? S_PAUSE : S_RUN;
    if (state == S_RUN && pcnt == PCNT_MAX) tick = 1'b1;
  end

  assign running = (state == S_RUN);

  // The tick uses the pre-edge state and dir, so simultaneous presses only affect later ticks.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pcnt     <= '0;
      dir      <= 1'b0;
      code_out <= 3'd0;
      step     <= 1'b0;
    end else begin
      if (state == S_RUN) pcnt <= tick ? '0 : pcnt + 1'b1;
      dir  <= dir ^ press[1];
      step <= tick;
      if (tick) code_out <= dir ? code_out - 3'd1 : code_out + 3'd1;
    end
  end

endmodule

// File: tb/tb_led_code_sequencer.sv
// Bench for led_code_sequencer (CNT_MAX=3, DEBOUNCE_MAX=4): vector table,
// hand-built corner sequences and random key activity against a reference model.
module tb_led_code_sequencer;

  localparam int CM = 3;
  localparam int DM = 4;
  localparam int P  = CM + 1;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       key_pause = 1'b1;
  logic       key_dir = 1'b1;
  logic [2:0] code_out;
  logic       step;
  logic       running;

  led_code_sequencer #(.CNT_MAX(CM), .DEBOUNCE_MAX(DM)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_pause (key_pause),
    .key_dir   (key_dir),
    .code_out  (code_out),
    .step      (step),
    .running   (running)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  // Reference model: code value, run/pause, direction, RUN-edge count and
  // the length of the current low run seen on each key.
  int m_code;
  int m_runedges;
  bit m_run, m_dir, m_step, m_pp, m_dp;
  int rq_p[$];
  int rq_d[$];

  logic [2:0] exp_q[$];

  typedef struct {
    int         edge_no;
    logic       kp;
    logic       kd;
    logic [2:0] code;
    logic       stp;
    logic       run;
  } vec_t;
  vec_t tbl[12];

  function void model_reset();
    m_code = 0; m_runedges = 0;
    m_run = 1'b1; m_dir = 1'b0; m_step = 1'b0; m_pp = 1'b0; m_dp = 1'b0;
    rq_p.delete(); rq_p.push_back(0); rq_p.push_back(0);
    rq_d.delete(); rq_d.push_back(0); rq_d.push_back(0);
  endfunction

  function void model_step(logic kp, logic kd);
    bit t;
    t = m_run && ((m_runedges % P) == P - 1);
    if (t) m_code = m_dir ? (m_code + 7) % 8 : (m_code + 1) % 8;
    m_step = t;
    if (m_run) m_runedges++;
    if (m_pp) m_run = ~m_run;
    if (m_dp) m_dir = ~m_dir;
    // A press is seen two sync stages after the key has been low DM samples in a row.
    rq_p.push_back(kp ? 0 : rq_p[rq_p.size()-1] + 1);
    rq_d.push_back(kd ? 0 : rq_d[rq_d.size()-1] + 1);
    if (rq_p.size() > 3) void'(rq_p.pop_front());
    if (rq_d.size() > 3) void'(rq_d.pop_front());
    m_pp = (rq_p[0] == DM);
    m_dp = (rq_d[0] == DM);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
    end
  endtask

  task automatic cycle();
    logic [4:0] e;
    @(posedge sys_clk);
    edge_n++;
    if (sys_rst_n) model_step(key_pause, key_dir);
    @(negedge sys_clk);
    e = {m_code[2:0], m_step, m_run};
    chk("model", {27'd0, code_out, step, running}, {27'd0, e});
  endtask

  task automatic apply_reset();
    key_pause = 1'b1;
    key_dir   = 1'b1;
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_code", {29'd0, code_out}, 32'd0);
    chk("rst_step", {31'd0, step}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd1);
    repeat (2) cycle();
    sys_rst_n = 1'b1;
    edge_n = 0;
  endtask

  task automatic run_table();
    for (int i = 0; i < 12; i++) begin
      key_pause = tbl[i].kp;
      key_dir   = tbl[i].kd;
      for (int b = 0; b < 64 && edge_n < tbl[i].edge_no; b++) cycle();
      chk("tbl_edge", edge_n, tbl[i].edge_no);
      chk("tbl_code", {29'd0, code_out}, {29'd0, tbl[i].code});
      chk("tbl_step", {31'd0, step}, {31'd0, tbl[i].stp});
      chk("tbl_running", {31'd0, running}, {31'd0, tbl[i].run});
    end
  endtask

  task automatic hold_pause(input int n);
    key_pause = 1'b0;
    repeat (n) cycle();
    key_pause = 1'b1;
  endtask

  initial begin
    int hp, hd, b;
    tbl[0]  = '{3,  1'b1, 1'b1, 3'd0, 1'b0, 1'b1};
    tbl[1]  = '{4,  1'b1, 1'b1, 3'd1, 1'b1, 1'b1};
    tbl[2]  = '{5,  1'b1, 1'b1, 3'd1, 1'b0, 1'b1};
    tbl[3]  = '{8,  1'b1, 1'b1, 3'd2, 1'b1, 1'b1};
    tbl[4]  = '{12, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1};
    tbl[5]  = '{16, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1};
    tbl[6]  = '{20, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1};
    tbl[7]  = '{24, 1'b1, 1'b1, 3'd6, 1'b1, 1'b1};
    tbl[8]  = '{27, 1'b1, 1'b1, 3'd6, 1'b0, 1'b1};
    tbl[9]  = '{28, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1};
    tbl[10] = '{31, 1'b1, 1'b1, 3'd7, 1'b0, 1'b1};
    tbl[11] = '{32, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1};

    // Reset and free run upward.
    #2;
    apply_reset();
    run_table();

    // Direction press starting at code 0 (edge 32): toggles at edge 39 while code is 1.
    exp_q.delete();
    exp_q.push_back(3'd1); exp_q.push_back(3'd0);
    exp_q.push_back(3'd7); exp_q.push_back(3'd6);
    key_dir = 1'b0;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (c == 10) key_dir = 1'b1;
      cycle();
      if (step) chk("dir_seq", {29'd0, code_out}, {29'd0, exp_q.pop_front()});
    end
    key_dir = 1'b1;
    chk("dir_seq_left", exp_q.size(), 0);
    chk("dir_edge", edge_n, 48);

    // Pause landing when pcnt goes 1->2 (edge 58), code 4, then resume.
    repeat (3) cycle();
    hold_pause(8);
    chk("pause_running", {31'd0, running}, 32'd0);
    chk("pause_code", {29'd0, code_out}, 32'd4);
    for (int c = 0; c < 50; c++) begin
      cycle();
      chk("paused_hold", {27'd0, code_out, step, running}, {27'd0, 3'd4, 1'b0, 1'b0});
    end
    hold_pause(6);
    cycle();
    chk("resume_running", {31'd0, running}, 32'd1);
    chk("resume_step0", {31'd0, step}, 32'd0);
    cycle();
    chk("resume_step1", {31'd0, step}, 32'd0);
    cycle();
    chk("resume_step2", {31'd0, step}, 32'd1);
    chk("resume_code", {29'd0, code_out}, 32'd3);

    // Bounce rejection, then one clean press.
    for (int r = 0; r < 4; r++) begin
      key_pause = 1'b0; repeat (3) cycle();
      key_pause = 1'b1; cycle();
    end
    repeat (6) cycle();
    chk("bounce_no_toggle", {31'd0, running}, 32'd1);
    hold_pause(7);
    repeat (2) cycle();
    chk("clean_toggle", {31'd0, running}, 32'd0);
    repeat (10) cycle();
    chk("clean_single", {31'd0, running}, 32'd0);

    // Pause and dir pulses coincide with the tick 5->6 at edge 24.
    #2;
    apply_reset();
    for (int c = 0; c < 30 && edge_n < 17; c++) cycle();
    key_pause = 1'b0;
    key_dir   = 1'b0;
    repeat (6) cycle();
    key_pause = 1'b1;
    key_dir   = 1'b1;
    cycle();
    chk("sim_edge", edge_n, 24);
    chk("sim_code", {29'd0, code_out}, 32'd6);
    chk("sim_step", {31'd0, step}, 32'd1);
    chk("sim_running", {31'd0, running}, 32'd0);
    repeat (10) cycle();
    chk("sim_frozen", {29'd0, code_out}, 32'd6);
    hold_pause(6);
    b = 0;
    while (b < 20 && !m_step) begin cycle(); b++; end
    chk("sim_timeout", {31'd0, m_step}, 32'd1);
    chk("sim_down", {29'd0, code_out}, 32'd5);

    // Pause at code 4 going down, partial dir press, then async reset.
    hold_pause(6);
    repeat (2) cycle();
    chk("pre_rst_code", {29'd0, code_out}, 32'd4);
    chk("pre_rst_running", {31'd0, running}, 32'd0);
    key_dir = 1'b0;
    repeat (4) cycle();
    #2;
    apply_reset();
    run_table();

    // Random key activity with occasional resets.
    hp = 0;
    hd = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        #2;
        apply_reset();
        hp = 0;
        hd = 0;
      end
      if (hp == 0) begin
        key_pause = ($urandom_range(0, 2) != 0);
        hp = $urandom_range(1, 10);
      end
      if (hd == 0) begin
        key_dir = ($urandom_range(0, 2) != 0);
        hd = $urandom_range(1, 10);
      end
      hp--;
      hd--;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
